conv_window_sequencer: RTL and testbench

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

---
 rtl/conv_window_sequencer.sv | 133 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Convolution window address sequencer: walks a 12x12 image as four 6x6 quadrants,
// emitting every 3x3 window tap (576 per pass) under a valid/ready handshake.
module conv_window_sequencer #(
    parameter int QUAD_DIM = 6,
    parameter int KERNEL   = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] pixel_row,
    output logic [3:0] pixel_col,
    output logic [1:0] quadrant,
    output logic       quadrant_lsb,
    output logic       new_row,
    output logic       new_vector,
    output logic [5:0] window_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] K_LAST = 2'(KERNEL - 1);
    localparam logic [1:0] W_LAST = 2'(QUAD_DIM - KERNEL);
    localparam logic [3:0] Q_OFS  = 4'(QUAD_DIM);

    state_t     state_r, state_s;
    logic [1:0] q_r, wr_r, wc_r, kr_r, kc_r;
    logic [1:0] q_s, wr_s, wc_s, kr_s, kc_s;
    logic [5:0] win_cnt_r, win_cnt_s;

    // Next state and tap-counter advance; counters move only on an accepted tap
    always_comb begin
        state_s   = state_r;
        q_s       = q_r;
        wr_s      = wr_r;
        wc_s      = wc_r;
        kr_s      = kr_r;
        kc_s      = kc_r;
        win_cnt_s = win_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_RUN;
                    win_cnt_s = 6'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ready) begin
                    if (kc_r == K_LAST) begin
                        kc_s = 2'd0;
                        if (kr_r == K_LAST) begin
                            kr_s      = 2'd0;
                            win_cnt_s = win_cnt_r + 6'd1;
                            if (wc_r == W_LAST) begin
                                wc_s = 2'd0;
                                if (wr_r == W_LAST) begin
                                    // quadrant wraps 3->0 so all counters are zero again in DONE
                                    wr_s = 2'd0;
                                    q_s  = q_r + 2'd1;
                                    if (q_r == 2'd3) begin
                                        state_s = ST_DONE;
                                    end else begin
                                        state_s = ST_RUN;
                                    end
                                end else begin
                                    wr_s = wr_r + 2'd1;
                                end
                            end else begin
                                wc_s = wc_r + 2'd1;
                            end
                        end else begin
                            kr_s = kr_r + 2'd1;
                        end
                    end else begin
                        kc_s = kc_r + 2'd1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r   <= ST_IDLE;
            q_r       <= 2'd0;
            wr_r      <= 2'd0;
            wc_r      <= 2'd0;
            kr_r      <= 2'd0;
            kc_r      <= 2'd0;
            win_cnt_r <= 6'd0;
        end else begin
            state_r   <= state_s;
            q_r       <= q_s;
            wr_r      <= wr_s;
            wc_r      <= wc_s;
            kr_r      <= kr_s;
            kc_r      <= kc_s;
            win_cnt_r <= win_cnt_s;
        end
    end

    // Control outputs are masked by clear so they read 0 during the clear cycle itself
    assign valid        = (state_r == ST_RUN) && !clear;
    assign busy         = (state_r != ST_IDLE) && !clear;
    assign done         = (state_r == ST_DONE) && !clear;
    assign new_row      = valid && (kc_r == K_LAST) && (kr_r != K_LAST);
    assign new_vector   = valid && (kc_r == K_LAST) && (kr_r == K_LAST);
    assign pixel_row    = (q_r[1] ? Q_OFS : 4'd0) + {2'b00, wr_r} + {2'b00, kr_r};
    assign pixel_col    = (q_r[0] ? Q_OFS : 4'd0) + {2'b00, wc_r} + {2'b00, kc_r};
    assign quadrant     = q_r;
    assign quadrant_lsb = q_r[0];
    // The internal count has wrapped to 0 after the 64th window; show it saturated
    assign window_count = (state_r == ST_DONE) ? 6'd63 : win_cnt_r;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: expected taps come from a nested-loop
// image walk; a negedge monitor pops and compares every accepted tap.
module tb_conv_window_sequencer;

    logic       clock = 1'b0;
    logic       clear, start, ready;
    logic       valid, quadrant_lsb, new_row, new_vector, busy, done;
    logic [3:0] pixel_row, pixel_col;
    logic [1:0] quadrant;
    logic [5:0] window_count;

    conv_window_sequencer dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .ready        (ready),
        .valid        (valid),
        .pixel_row    (pixel_row),
        .pixel_col    (pixel_col),
        .quadrant     (quadrant),
        .quadrant_lsb (quadrant_lsb),
        .new_row      (new_row),
        .new_vector   (new_vector),
        .window_count (window_count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int row;
        int col;
        int quad;
        int nr;
        int nv;
        int wcnt;
    } tap_t;

    tap_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_total = 0, nv_total = 0, nr_total = 0, done_total = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference walk over the image: quadrant, window row/col, kernel row/col
    task automatic push_pass();
        tap_t t;
        int   w;
        w = 0;
        for (int q = 0; q < 4; q++)
            for (int wr = 0; wr < 4; wr++)
                for (int wc = 0; wc < 4; wc++)
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++) begin
                            t.row  = 6 * (q / 2) + wr + kr;
                            t.col  = 6 * (q % 2) + wc + kc;
                            t.quad = q;
                            t.nr   = (kc == 2 && kr != 2) ? 1 : 0;
                            t.nv   = (kc == 2 && kr == 2) ? 1 : 0;
                            t.wcnt = w;
                            exp_q.push_back(t);
                            if (t.nv == 1) w++;
                        end
    endtask

    // Monitor: every accepted tap is compared against the scoreboard head
    always @(negedge clock) begin
        tap_t t;
        if (done) done_total++;
        if (valid && ready) begin
            acc_total++;
            if (new_vector) nv_total++;
            if (new_row) nr_total++;
            if (exp_q.size() == 0) begin
                check("unexpected_tap", 1, 0);
            end else begin
                t = exp_q.pop_front();
                check("pixel_row", int'(pixel_row), t.row);
                check("pixel_col", int'(pixel_col), t.col);
                check("quadrant", int'(quadrant), t.quad);
                check("quadrant_lsb", int'(quadrant_lsb), t.quad % 2);
                check("new_row", int'(new_row), t.nr);
                check("new_vector", int'(new_vector), t.nv);
                check("window_count", int'(window_count), t.wcnt);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int base_acc, base_nv, base_nr, base_done, cyc, done_cyc, tap;
    bit pulsed;

    initial begin
        clear = 1'b1; start = 1'b1; ready = 1'b1;
        tick(); tick();
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        clear = 1'b0; start = 1'b0;
        check("reset_window_count", int'(window_count), 0);
        check("reset_pixel_row", int'(pixel_row), 0);
        check("reset_pixel_col", int'(pixel_col), 0);
        check("idle_busy_after_clear", int'(busy), 0);

        // Pass 1: ready=1, ignored start during RUN (tap 50) and DONE
        push_pass();
        base_acc = acc_total; base_done = done_total;
        start = 1'b1; tick(); start = 1'b0;
        check("first_tap_valid", int'(valid), 1);
        done_cyc = -1; pulsed = 1'b0;
        for (cyc = 1; cyc <= 700; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tap = acc_total - base_acc + 1;
            start = (tap == 50 && !pulsed);
            if (tap == 50) pulsed = 1'b1;
            tick();
            start = 1'b0;
        end
        check("done_latency", done_cyc, 577);
        check("done_window_count", int'(window_count), 63);
        check("done_busy", int'(busy), 1);
        check("done_valid", int'(valid), 0);
        start = 1'b1; tick(); start = 1'b0;
        check("after_done_busy", int'(busy), 0);
        check("after_done_done", int'(done), 0);
        tick();
        check("start_in_done_ignored", int'(busy), 0);
        check("pass1_taps", acc_total - base_acc, 576);
        check("pass1_done_count", done_total - base_done, 1);
        check("pass1_queue_empty", exp_q.size(), 0);

        // Pass 2: stall on tap 9, then abort at tap 200
        push_pass();
        base_acc = acc_total; base_done = done_total;
        start = 1'b1; tick(); start = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            tap = acc_total - base_acc + 1;
            if (tap == 9 && ready) begin
                ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    check("stall_new_vector", int'(new_vector), 1);
                    check("stall_pixel_row", int'(pixel_row), 2);
                    check("stall_pixel_col", int'(pixel_col), 2);
                    check("stall_window_count", int'(window_count), 0);
                    tick();
                end
                ready = 1'b1;
                tick();
                check("window_count_after_stall", int'(window_count), 1);
            end else if (tap == 200) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                break;
            end else begin
                tick();
            end
        end
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_window_count", int'(window_count), 0);
        check("abort_taps_accepted", acc_total - base_acc, 199);
        exp_q.delete();
        tick(); tick(); tick();
        check("abort_no_restart", int'(busy), 0);
        check("abort_no_done", done_total - base_done, 0);

        // Pass 3: random 50% ready over a full pass
        push_pass();
        base_acc = acc_total; base_nv = nv_total; base_nr = nr_total; base_done = done_total;
        start = 1'b1; tick(); start = 1'b0;
        done_cyc = -1;
        for (cyc = 1; cyc <= 4000; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1'b1;
        check("pass3_finished", (done_cyc > 0) ? 1 : 0, 1);
        tick();
        check("pass3_taps", acc_total - base_acc, 576);
        check("pass3_new_vectors", nv_total - base_nv, 64);
        check("pass3_new_rows", nr_total - base_nr, 128);
        check("pass3_done_count", done_total - base_done, 1);
        check("pass3_queue_empty", exp_q.size(), 0);
        check("pass3_idle_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
